hazard_ctrl: RTL and testbench

- Central stall/flush/forwarding controller for the 5-stage MIPS pipeline.
- Consumes the instruction words held in the D/E/M/W pipeline registers.
- Drives the stall input of the D register, and the stall (bubble) input of the E register.
- Drives forwarding-mux selects for the D, E and M stages.
- Contains the multiply/divide busy sequencer, so HI/LO hazards stall correctly.

---
 rtl/hazard_ctrl.sv | 242 ++++++++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Purpose:
//   Central stall / flush / forwarding controller for the 5-stage MIPS
//   pipeline. Decodes the instruction words held in the D/E/M/W pipeline
//   registers and derives the stalls and forwarding-mux selects. It also
//   contains the multiply/divide busy sequencer, so HI/LO consumers wait
//   for the MD unit.
//
// Parameters:
//   MULT_CYCLES  busy cycles after a mult leaves E (1..15)
//   DIV_CYCLES   busy cycles after a div leaves E (1..15)
//
// Ports:
//   Clk       in   pipeline clock, rising edge
//   Rst_n     in   asynchronous active-low reset
//   InstrD    in   instruction word in the D register
//   InstrE    in   instruction word in the E register
//   InstrM    in   instruction word in the M register
//   InstrW    in   instruction word in the W register
//   StallF    out  hold PC
//   StallD    out  stall of the D register
//   FlushE    out  bubble insert into the E register
//   FwdRsD    out  D rs select: 0=RF, 1=M result
//   FwdRtD    out  D rt select: 0=RF, 1=M result
//   FwdRsE    out  E rs select: 0=pipe, 1=M result, 2=W result
//   FwdRtE    out  E rt select: 0=pipe, 1=M result, 2=W result
//   FwdRtM    out  M rt select: 0=pipe, 1=W result
//   MdBusy    out  multiply/divide unit busy
//   StallCnt  out  number of rising edges with StallD=1 (HAZARD_STATS_EN only)
//
// Configuration macro:
//   HAZARD_STATS_EN  adds the StallCnt port and its counter.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [31:0] InstrD,
  input  logic [31:0] InstrE,
  input  logic [31:0] InstrM,
  input  logic [31:0] InstrW,
  output logic        StallF,
  output logic        StallD,
  output logic        FlushE,
  output logic        FwdRsD,
  output logic        FwdRtD,
  output logic [1:0]  FwdRsE,
  output logic [1:0]  FwdRtE,
  output logic        FwdRtM,
  output logic        MdBusy
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] StallCnt
`endif
);

  // Everything the hazard logic needs to know about one instruction word.
  // dst is 0 for instructions without a destination, so a zero destination
  // and "no destination" are handled by the same comparison.
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] dst;
    logic       useRs;
    logic       useRt;
    logic [1:0] tuseRs;
    logic [1:0] tuseRt;
    logic [1:0] tnewE;
    logic [1:0] tnewM;
    logic       isMult;
    logic       isDiv;
    logic       isMdOp;
  } decT;

  function automatic decT decode(input logic [31:0] instr);
    decT        d;
    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] unusedShamt;
    logic       special;
    logic       isAlu, isJr, isMult, isDiv, isMfhi, isMflo;
    logic       isOri, isLui, isLw, isSw, isBeq, isJal;

    d     = '0;
    op    = instr[31:26];
    funct = instr[5:0];
    // shamt plays no part in hazard detection.
    unusedShamt = instr[10:6];

    special = (op == 6'h00);
    isAlu   = special && ((funct == 6'h21) || (funct == 6'h23));
    isJr    = special && (funct == 6'h08);
    isMult  = special && (funct == 6'h18);
    isDiv   = special && (funct == 6'h1a);
    isMfhi  = special && (funct == 6'h10);
    isMflo  = special && (funct == 6'h12);
    isOri   = (op == 6'h0d);
    isLui   = (op == 6'h0f);
    isLw    = (op == 6'h23);
    isSw    = (op == 6'h2b);
    isBeq   = (op == 6'h04);
    isJal   = (op == 6'h03);

    d.rs = instr[25:21];
    d.rt = instr[20:16];

    if (isAlu || isMfhi || isMflo) begin
      d.dst = instr[15:11];
    end else if (isOri || isLui || isLw) begin
      d.dst = instr[20:16];
    end else if (isJal) begin
      d.dst = 5'd31;
    end

    d.useRs  = isBeq || isJr || isAlu || isOri || isLw || isSw || isMult || isDiv;
    d.tuseRs = (isBeq || isJr) ? 2'd0 : 2'd1;
    d.useRt  = isBeq || isAlu || isMult || isDiv || isSw;
    d.tuseRt = isSw ? 2'd2 : (isBeq ? 2'd0 : 2'd1);

    if (isLw) begin
      d.tnewE = 2'd2;
    end else if (isAlu || isOri || isLui || isMfhi || isMflo) begin
      d.tnewE = 2'd1;
    end
    d.tnewM = isLw ? 2'd1 : 2'd0;

    d.isMult = isMult;
    d.isDiv  = isDiv;
    d.isMdOp = isMult || isDiv || isMfhi || isMflo;
    return d;
  endfunction

  decT        decD, decE, decM, decW;
  logic       unusedDec;
  logic [3:0] cnt_q, cnt_d;
  logic       dataStall, mdStall, stall;
  logic       fwdRsD, fwdRtD, fwdRtM;
  logic [1:0] fwdRsE, fwdRtE;

  assign decD = decode(InstrD);
  assign decE = decode(InstrE);
  assign decM = decode(InstrM);
  assign decW = decode(InstrW);

  // Not every decoded field is consumed for every stage.
  assign unusedDec = ^{decD, decE, decM, decW};

  // A D source stalls when a matching producer in E or M will not have its
  // result ready by the time D needs it. Checking rs/rt != 0 also covers the
  // "no destination" case because such producers decode to dst = 0.
  always_comb begin
    dataStall = 1'b0;
    if (decD.useRs && (decD.rs != 5'd0)) begin
      if ((decD.rs == decE.dst) && (decD.tuseRs < decE.tnewE)) dataStall = 1'b1;
      if ((decD.rs == decM.dst) && (decD.tuseRs < decM.tnewM)) dataStall = 1'b1;
    end
    if (decD.useRt && (decD.rt != 5'd0)) begin
      if ((decD.rt == decE.dst) && (decD.tuseRt < decE.tnewE)) dataStall = 1'b1;
      if ((decD.rt == decM.dst) && (decD.tuseRt < decM.tnewM)) dataStall = 1'b1;
    end
    mdStall = decD.isMdOp && ((cnt_q != 4'd0) || decE.isMult || decE.isDiv);
    stall   = dataStall || mdStall;
  end

  // Forwarding: the nearest stage holding a ready matching result wins.
  // D only has an M path because the register file is write-through.
  always_comb begin
    fwdRsD = (decM.dst != 5'd0) && (decM.dst == decD.rs) && (decM.tnewM == 2'd0);
    fwdRtD = (decM.dst != 5'd0) && (decM.dst == decD.rt) && (decM.tnewM == 2'd0);

    fwdRsE = 2'd0;
    if ((decM.dst != 5'd0) && (decM.dst == decE.rs) && (decM.tnewM == 2'd0)) begin
      fwdRsE = 2'd1;
    end else if ((decW.dst != 5'd0) && (decW.dst == decE.rs)) begin
      fwdRsE = 2'd2;
    end

    fwdRtE = 2'd0;
    if ((decM.dst != 5'd0) && (decM.dst == decE.rt) && (decM.tnewM == 2'd0)) begin
      fwdRtE = 2'd1;
    end else if ((decW.dst != 5'd0) && (decW.dst == decE.rt)) begin
      fwdRtE = 2'd2;
    end

    fwdRtM = (decW.dst != 5'd0) && (decW.dst == decM.rt);
  end

  // All combinational controls are forced inactive while reset is held.
  always_comb begin
    StallF = Rst_n && stall;
    StallD = Rst_n && stall;
    FlushE = Rst_n && stall;
    FwdRsD = Rst_n && fwdRsD;
    FwdRtD = Rst_n && fwdRtD;
    FwdRsE = Rst_n ? fwdRsE : 2'd0;
    FwdRtE = Rst_n ? fwdRtE : 2'd0;
    FwdRtM = Rst_n && fwdRtM;
  end

  // MD sequencer: a mult/div in E (re)loads the busy count, taking priority
  // over the decrement, so a back-to-back MD op restarts the wait.
  always_comb begin
    cnt_d = cnt_q;
    if (decE.isMult) begin
      cnt_d = 4'(MULT_CYCLES);
    end else if (decE.isDiv) begin
      cnt_d = 4'(DIV_CYCLES);
    end else if (cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign MdBusy = (cnt_q != 4'd0);

`ifdef HAZARD_STATS_EN
  logic [31:0] stallCnt_q;

  // Free-running count of stalled edges; wraps naturally at 2^32.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stallCnt_q <= 32'd0;
    end else if (stall) begin
      stallCnt_q <= stallCnt_q + 32'd1;
    end
  end

  assign StallCnt = stallCnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed testbench for hazard_ctrl: load-use stall, branch stall and
// D-stage forwarding, $0 handling, E/M forwarding priority, MD busy
// sequencing for mult and div, and asynchronous reset mid-count.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam logic [31:0] NOP        = 32'h00000000;
  localparam logic [31:0] ADDU_3_1_2 = 32'h00221821;
  localparam logic [31:0] LW_1_4     = 32'h8c810000;
  localparam logic [31:0] BEQ_5_0    = 32'h10a00004;
  localparam logic [31:0] ADDU_5_1_2 = 32'h00222821;
  localparam logic [31:0] MULT_1_2   = 32'h00220018;
  localparam logic [31:0] DIV_1_2    = 32'h0022001a;
  localparam logic [31:0] MFLO_3     = 32'h00001812;
  localparam logic [31:0] ADDU_0_1_2 = 32'h00220021;
  localparam logic [31:0] ADDU_8_0_2 = 32'h00024021;
  localparam logic [31:0] ADDU_8_1_7 = 32'h00274021;
  localparam logic [31:0] ORI_7      = 32'h34070005;
  localparam logic [31:0] LW_7_4     = 32'h8c870000;
  localparam logic [31:0] SW_7_4     = 32'hac870000;

  logic        Clk;
  logic        Rst_n;
  logic [31:0] InstrD, InstrE, InstrM, InstrW;
  logic        StallF, StallD, FlushE;
  logic        FwdRsD, FwdRtD, FwdRtM;
  logic [1:0]  FwdRsE, FwdRtE;
  logic        MdBusy;
`ifdef HAZARD_STATS_EN
  logic [31:0] StallCnt;
`endif

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  hazard_ctrl #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .InstrD  (InstrD),
    .InstrE  (InstrE),
    .InstrM  (InstrM),
    .InstrW  (InstrW),
    .StallF  (StallF),
    .StallD  (StallD),
    .FlushE  (FlushE),
    .FwdRsD  (FwdRsD),
    .FwdRtD  (FwdRtD),
    .FwdRsE  (FwdRsE),
    .FwdRtE  (FwdRtE),
    .FwdRtM  (FwdRtM),
    .MdBusy  (MdBusy)
`ifdef HAZARD_STATS_EN
    ,
    .StallCnt(StallCnt)
`endif
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Hard bound on total run time.
  initial begin
    #50000;
    $display("[TB] FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // New pipeline contents appear just after a rising edge.
  task automatic applyStimulus(input logic [31:0] d, input logic [31:0] e,
                               input logic [31:0] m, input logic [31:0] w);
    @(posedge Clk);
    #1;
    InstrD = d;
    InstrE = e;
    InstrM = m;
    InstrW = w;
  endtask

  task automatic checkOutput(input string tag, input logic expStall,
                             input logic expFwdRsD, input logic expFwdRtD,
                             input logic [1:0] expFwdRsE, input logic [1:0] expFwdRtE,
                             input logic expFwdRtM, input logic expMdBusy);
    logic [10:0] obsVec;
    logic [10:0] expVec;
    obsVec = {StallF, StallD, FlushE, FwdRsD, FwdRtD, FwdRsE, FwdRtE, FwdRtM, MdBusy};
    expVec = {expStall, expStall, expStall, expFwdRsD, expFwdRtD, expFwdRsE, expFwdRtE,
              expFwdRtM, expMdBusy};
    checkCount++;
    assert (obsVec === expVec) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%b required=%b (StallF StallD FlushE FwdRsD FwdRtD FwdRsE FwdRtE FwdRtM MdBusy)",
             tag, obsVec, expVec);
    end
  endtask

  initial begin
    Rst_n  = 1'b0;
    InstrD = NOP;
    InstrE = NOP;
    InstrM = NOP;
    InstrW = NOP;

    // Outputs must stay inactive under reset even with a live hazard.
    applyStimulus(ADDU_3_1_2, LW_1_4, NOP, NOP);
    @(negedge Clk);
    checkOutput("reset hold", 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
`ifdef HAZARD_STATS_EN
    checkCount++;
    assert (StallCnt === 32'd0) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL stallcnt reset: observed=%0d required=0", StallCnt);
    end
`endif
    #2 Rst_n = 1'b1;

    // Load-use: one stall cycle, then the bubble, then W forwarding into E.
    applyStimulus(ADDU_3_1_2, LW_1_4, NOP, NOP);
    @(negedge Clk);
    checkOutput("load-use stall", 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    applyStimulus(ADDU_3_1_2, NOP, LW_1_4, NOP);
    @(negedge Clk);
    checkOutput("load-use release", 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    applyStimulus(NOP, ADDU_3_1_2, NOP, LW_1_4);
    @(negedge Clk);
    checkOutput("load-use fwd W", 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 1'b0, 1'b0);

    // Branch: addu in E stalls beq, then the M result forwards into D.
    applyStimulus(BEQ_5_0, ADDU_5_1_2, NOP, NOP);
    @(negedge Clk);
    checkOutput("beq stall E", 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    applyStimulus(BEQ_5_0, NOP, ADDU_5_1_2, NOP);
    @(negedge Clk);
    checkOutput("beq fwd M", 1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);

    // Destination $0 never forwards.
    applyStimulus(NOP, ADDU_8_0_2, ADDU_0_1_2, NOP);
    @(negedge Clk);
    checkOutput("dest zero", 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);

    // M beats W for E rt; W also matches M's rt field (ori writes $7).
    applyStimulus(NOP, ADDU_8_1_7, ORI_7, LW_7_4);
    @(negedge Clk);
    checkOutput("rtE M wins", 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 1'b1, 1'b0);
    applyStimulus(NOP, ADDU_8_1_7, NOP, LW_7_4);
    @(negedge Clk);
    checkOutput("rtE from W", 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 1'b0, 1'b0);
    applyStimulus(NOP, NOP, SW_7_4, LW_7_4);
    @(negedge Clk);
    checkOutput("rtM from W", 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0);

    // mflo behind mult: 1 + 5 stall cycles, busy on cycles 1..5.
    applyStimulus(MFLO_3, MULT_1_2, NOP, NOP);
    @(negedge Clk);
    checkOutput("mult k=0", 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(MFLO_3, NOP, NOP, NOP);
      @(negedge Clk);
      checkOutput($sformatf("mult k=%0d", k), (k <= 5), 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, (k <= 5));
    end

    // mflo behind div: 1 + 10 stall cycles.
    applyStimulus(MFLO_3, DIV_1_2, NOP, NOP);
    @(negedge Clk);
    checkOutput("div k=0", 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(MFLO_3, NOP, NOP, NOP);
      @(negedge Clk);
      checkOutput($sformatf("div k=%0d", k), (k <= 10), 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, (k <= 10));
    end

    // Reset while the count sits at 3 aborts it for good.
    applyStimulus(NOP, MULT_1_2, NOP, NOP);
    @(negedge Clk);
    checkOutput("mult load", 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    for (int k = 5; k >= 3; k--) begin
      applyStimulus(NOP, NOP, NOP, NOP);
      @(negedge Clk);
      checkOutput($sformatf("count %0d", k), 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);
    end
    #2 Rst_n = 1'b0;
    #1;
    checkOutput("reset mid count", 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    @(negedge Clk);
    Rst_n = 1'b1;
    applyStimulus(NOP, NOP, NOP, NOP);
    @(negedge Clk);
    checkOutput("no resume", 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    applyStimulus(NOP, DIV_1_2, NOP, NOP);
    @(negedge Clk);
    checkOutput("post reset div", 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
    applyStimulus(NOP, NOP, NOP, NOP);
    @(negedge Clk);
    checkOutput("post reset busy", 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1);

`ifdef HAZARD_STATS_EN
    // Four stalled edges after a fresh reset give a count of 4.
    #2 Rst_n = 1'b0;
    InstrD = NOP;
    InstrE = NOP;
    @(negedge Clk);
    Rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(ADDU_3_1_2, LW_1_4, NOP, NOP);
    end
    applyStimulus(NOP, NOP, NOP, NOP);
    @(negedge Clk);
    checkCount++;
    assert (StallCnt === 32'd4) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL stallcnt four: observed=%0d required=4", StallCnt);
    end
    Rst_n = 1'b0;
    #1;
    checkCount++;
    assert (StallCnt === 32'd0) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL stallcnt clear: observed=%0d required=0", StallCnt);
    end
    Rst_n = 1'b1;
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
